d_cache_ctrl: RTL and testbench
===============================

D_CACHE_CTRL -- requirements
Module: d_cache_ctrl

Interface
REQ-001 SHALL have no parameters; geometry is fixed: 32 lines, 1 word per line, tag = addr[12:5], index = addr[4:0].
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous reset, active-low.
REQ-004 cpu_addr  in  13  CPU word address.
REQ-005 cpu_re  in  1  CPU load request.
REQ-006 cpu_we  in  1  CPU store request.
REQ-007 cpu_wdata  in  16  store data.
REQ-008 cpu_rdata  out  16  load data; valid in any cycle with cpu_re=1 and stall=0.
REQ-009 stall  out  1  combinational; 1 = CPU holds request and pipeline.
REQ-010 mem_addr  out  13  address to data memory.
REQ-011 mem_re  out  1  data memory read strobe.
REQ-012 mem_we  out  1  data memory write strobe.
REQ-013 mem_wdata  out  16  write-back data.
REQ-014 mem_rdata  in  16  data memory read data; sampled at the posedge ending the mem_re cycle.

Function
REQ-015 Direct-mapped, write-back, write-allocate; per line: valid, dirty, 8-bit tag, 16-bit data.
REQ-016 hit = (cpu_re^cpu_we) & valid[idx] & tag[idx]==cpu_addr[12:5]; evaluated combinationally in IDLE and DONE.
REQ-017 Load hit: cpu_rdata = data[idx] same cycle, stall=0.
REQ-018 Store hit: data[idx]<=cpu_wdata, dirty[idx]<=1 at posedge, stall=0.
REQ-019 cpu_re=cpu_we=1 or both 0: no-op, stall=0, no memory traffic, arrays unchanged.
REQ-020 FSM states IDLE, WB, FILL, DONE; reset state IDLE.
REQ-021 IDLE, miss, victim dirty -> WB; IDLE, miss, victim clean or invalid -> FILL; IDLE, hit/no-op -> IDLE.
REQ-022 WB (1 cycle): mem_we=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx]; -> FILL.
REQ-023 FILL (1 cycle): mem_re=1, mem_addr=cpu_addr; at posedge data[idx]<=mem_rdata, tag[idx]<=cpu_addr[12:5], valid<=1, dirty<=0; -> DONE.
REQ-024 DONE: request serviced as hit per REQ-017/018, stall=0; -> IDLE.
REQ-025 stall=1 in IDLE on miss, in WB, in FILL; 0 otherwise. Clean-miss penalty 2 cycles, dirty-miss penalty 3 cycles.
REQ-026 mem_re and mem_we SHALL never both be 1; both 0 in IDLE and DONE.
REQ-027 cpu_addr/re/we/wdata SHALL be held stable by CPU while stall=1; the controller does not latch them.
REQ-028 Request dropped (re=we=0) while in WB or FILL: the sequence completes, the line is filled, DONE performs no access.
REQ-029 mem_addr SHALL equal cpu_addr when neither mem_re nor mem_we is asserted.

Reset
REQ-030 rst_n low: state=IDLE, all valid and dirty bits=0, stall=0, mem_re=mem_we=0, cpu_rdata=0 when no hit, mem_wdata=0.
REQ-031 Reset asserted mid-WB or mid-FILL SHALL abort the transaction with no further memory strobes; the partially processed line ends invalid.
REQ-032 Tag and data arrays need not be reset.

Structure
REQ-033 Package d_cache_pkg: state enum (IDLE, WB, FILL, DONE), TAG_W=8, IDX_W=5, LINES=32, WORD_W=16.
REQ-034 One sub-module, d_cache_array: tag/data/valid/dirty storage with one write port and an async-read port; FSM and hit logic stay in d_cache_ctrl.

Verification
REQ-035 Reset, load 0x0005 -> stall 2 cycles, mem_re with mem_addr=0x0005, then cpu_rdata=mem[0x0005]; repeat load -> stall=0.
REQ-036 Store 0x1234 to 0x0005 after fill -> no memory strobe, dirty[5]=1; load 0x0005 -> 0x1234.
REQ-037 Then load 0x0025 (same idx, tag 1) -> stall 3 cycles, WB writes 0x1234 to 0x0005, FILL reads 0x0025.
REQ-038 Store miss to 0x0100 -> FILL reads 0x0100, DONE writes cpu_wdata, dirty set; no WB for clean victim.
REQ-039 cpu_re=cpu_we=1 on any address -> stall=0, no mem strobes, arrays unchanged.
REQ-040 rst_n pulsed low during WB -> mem_we drops at once, state IDLE, next access to same address misses.

Source files
------------

// File: rtl/d_cache_pkg.sv
// Shared geometry, FSM state encoding and line payload for the data cache controller.
package d_cache_pkg;

    localparam int unsigned TAG_W  = 8;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned LINES  = 32;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_e;

    // One cache line as seen by the array's read and write ports.
    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [TAG_W-1:0]  tag;
        logic [WORD_W-1:0] data;
    } line_t;

endpackage

// File: rtl/d_cache_array.sv
// Line storage for the direct-mapped cache: one write port, one async read port.
module d_cache_array
    import d_cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_line
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD_W-1:0] data_q [LINES];

    // Status bits are cleared by reset so every line starts invalid and clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_line.valid;
            dirty_q[wr_idx] <= wr_line.dirty;
        end
    end

    // Tag and data payload carry no reset; they are qualified by valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_line.tag;
            data_q[wr_idx] <= wr_line.data;
        end
    end

    // Asynchronous read of the addressed line.
    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_idx];
        rd_line.dirty = dirty_q[rd_idx];
        rd_line.tag   = tag_q[rd_idx];
        rd_line.data  = data_q[rd_idx];
    end

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller, one word per line.
module d_cache_ctrl
    import d_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_e           state;
    state_e           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             req;
    logic             hit;
    line_t            rd_line;
    logic             wr_en;
    line_t            wr_line;

    assign idx = cpu_addr[IDX_W-1:0];
    assign tag = cpu_addr[ADDR_W-1:IDX_W];
    assign req = cpu_re ^ cpu_we;
    assign hit = req & rd_line.valid & (rd_line.tag == tag);

    d_cache_array u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (idx),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_line (wr_line)
    );

    // State register; reset aborts any write-back or fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, memory strobes and array write; strobes decode from state so they drop with reset.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = '0;
        cpu_rdata = '0;
        wr_en     = 1'b0;
        wr_line   = '0;

        case (state)
            IDLE, DONE: begin
                if (hit) begin
                    if (cpu_re) begin
                        cpu_rdata = rd_line.data;
                    end else begin
                        wr_en         = 1'b1;
                        wr_line.valid = 1'b1;
                        wr_line.dirty = 1'b1;
                        wr_line.tag   = tag;
                        wr_line.data  = cpu_wdata;
                    end
                end
                if (state == DONE) begin
                    state_nxt = IDLE;
                end else if (req && !hit) begin
                    stall     = 1'b1;
                    state_nxt = (rd_line.valid && rd_line.dirty) ? WB : FILL;
                end
            end
            WB: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_line.tag, idx};
                mem_wdata = rd_line.data;
                state_nxt = FILL;
            end
            FILL: begin
                stall         = 1'b1;
                mem_re        = 1'b1;
                wr_en         = 1'b1;
                wr_line.valid = 1'b1;
                wr_line.dirty = 1'b0;
                wr_line.tag   = tag;
                wr_line.data  = mem_rdata;
                state_nxt     = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Bench for d_cache_ctrl: transaction-level cache/memory model feeding a per-cycle compare queue.
module tb_d_cache_ctrl;

    logic        clk;
    logic        rst_n;
    logic [12:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic [12:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    d_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing data memory driven by the DUT.
    logic [15:0] dev_mem [0:8191];
    assign mem_rdata = dev_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr] <= mem_wdata;
    end

    // Reference model: plain arrays for memory contents and cache lines.
    logic [15:0] mdl_mem   [0:8191];
    logic        mdl_valid [0:31];
    logic        mdl_dirty [0:31];
    logic [7:0]  mdl_tag   [0:31];
    logic [15:0] mdl_data  [0:31];

    typedef struct packed {
        logic        stall;
        logic        mre;
        logic        mwe;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q [$];
    exp_t cmp_e;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model's expected cycle sequence.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            chk("stall",     16'(stall),     16'(cmp_e.stall));
            chk("mem_re",    16'(mem_re),    16'(cmp_e.mre));
            chk("mem_we",    16'(mem_we),    16'(cmp_e.mwe));
            chk("mem_addr",  16'(mem_addr),  16'(cmp_e.addr));
            chk("mem_wdata", mem_wdata,      cmp_e.wdata);
            chk("cpu_rdata", cpu_rdata,      cmp_e.rdata);
        end
    end

    // One CPU access: model predicts every cycle until the request completes.
    task automatic access(input logic [12:0] a, input logic re, input logic we,
                          input logic [15:0] wd, input bit drop);
        exp_t       e;
        int         n;
        logic [4:0] ix;
        logic [7:0] tg;
        ix = a[4:0];
        tg = a[12:5];
        cpu_addr  = a;
        cpu_re    = re;
        cpu_we    = we;
        cpu_wdata = wd;
        e = '0;
        e.addr = a;
        n = 0;
        if (!(re ^ we)) begin
            exp_q.push_back(e);
            n = 1;
        end else if (mdl_valid[ix] && mdl_tag[ix] == tg) begin
            e.rdata = re ? mdl_data[ix] : 16'h0;
            exp_q.push_back(e);
            n = 1;
            if (we) begin
                mdl_data[ix]  = wd;
                mdl_dirty[ix] = 1'b1;
            end
        end else begin
            e.stall = 1'b1;
            exp_q.push_back(e);
            n = 1;
            if (mdl_valid[ix] && mdl_dirty[ix]) begin
                e.mwe   = 1'b1;
                e.addr  = {mdl_tag[ix], ix};
                e.wdata = mdl_data[ix];
                exp_q.push_back(e);
                mdl_mem[{mdl_tag[ix], ix}] = mdl_data[ix];
                n++;
            end
            e = '0;
            e.stall = 1'b1;
            e.mre   = 1'b1;
            e.addr  = a;
            exp_q.push_back(e);
            mdl_valid[ix] = 1'b1;
            mdl_dirty[ix] = 1'b0;
            mdl_tag[ix]   = tg;
            mdl_data[ix]  = mdl_mem[a];
            n++;
            e = '0;
            e.addr = a;
            if (!drop) begin
                e.rdata = re ? mdl_data[ix] : 16'h0;
                if (we) begin
                    mdl_data[ix]  = wd;
                    mdl_dirty[ix] = 1'b1;
                end
            end
            exp_q.push_back(e);
            n++;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (drop && i == 0) begin
                cpu_re = 1'b0;
                cpu_we = 1'b0;
            end
        end
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    // Single-cycle load expected to hit, checked against a hand-computed literal.
    task automatic peek_load(input logic [12:0] a, input logic [15:0] req);
        cpu_addr = a;
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        @(negedge clk);
        chk("peek_stall", 16'(stall), 16'h0);
        chk("peek_rdata", cpu_rdata, req);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mdl_valid[i] = 1'b0;
            mdl_dirty[i] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8192; i++) begin
            dev_mem[i] = 16'(i) ^ 16'h5A00;
            mdl_mem[i] = 16'(i) ^ 16'h5A00;
        end
        for (int i = 0; i < 32; i++) begin
            mdl_tag[i]  = '0;
            mdl_data[i] = '0;
        end
        model_reset();
        rst_n     = 1'b0;
        cpu_addr  = 13'h0005;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = 16'h0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_stall",     16'(stall),    16'h0);
        chk("rst_mem_re",    16'(mem_re),   16'h0);
        chk("rst_mem_we",    16'(mem_we),   16'h0);
        chk("rst_cpu_rdata", cpu_rdata,     16'h0);
        chk("rst_mem_wdata", mem_wdata,     16'h0);
        chk("rst_mem_addr",  16'(mem_addr), 16'h0005);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean load miss, then repeat as a hit.
        access(13'h0005, 1'b1, 1'b0, 16'h0, 1'b0);
        peek_load(13'h0005, 16'h5A05);

        // Store hit, then load back.
        access(13'h0005, 1'b0, 1'b1, 16'h1234, 1'b0);
        peek_load(13'h0005, 16'h1234);

        // Dirty miss to same index: write-back then fill.
        access(13'h0025, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("wb_mem_5", dev_mem[5], 16'h1234);
        peek_load(13'h0025, 16'h5A25);

        // Store miss to an invalid line.
        access(13'h0100, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        peek_load(13'h0100, 16'hBEEF);

        // Simultaneous load and store is a no-op.
        access(13'h0100, 1'b1, 1'b1, 16'h0777, 1'b0);
        access(13'h1F00, 1'b1, 1'b1, 16'h0888, 1'b0);
        peek_load(13'h0100, 16'hBEEF);

        // Request withdrawn during the fill: line still allocated.
        access(13'h0042, 1'b1, 1'b0, 16'h0, 1'b1);
        peek_load(13'h0042, 16'h5A42);

        // Mixed traffic across a few tags and indices.
        for (int i = 0; i < 24; i++) begin
            access(13'({8'(i % 3), 5'((i * 7) % 8)}), 1'(i % 2), 1'((i + 1) % 2),
                   16'h1000 + 16'(i), 1'b0);
        end

        // Reset asserted during a write-back.
        access(13'h0003, 1'b0, 1'b1, 16'hCAFE, 1'b0);
        cpu_addr = 13'h0023;
        cpu_re   = 1'b1;
        cpu_we   = 1'b0;
        @(negedge clk);
        chk("abort_idle_stall", 16'(stall), 16'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_wb_we",    16'(mem_we),   16'h1);
        chk("abort_wb_addr",  16'(mem_addr), 16'h0003);
        chk("abort_wb_wdata", mem_wdata,     16'hCAFE);
        #1;
        rst_n  = 1'b0;
        cpu_re = 1'b0;
        #1;
        chk("abort_we_drop", 16'(mem_we),  16'h0);
        chk("abort_re",      16'(mem_re),  16'h0);
        chk("abort_stall",   16'(stall),   16'h0);
        chk("abort_wdata",   mem_wdata,    16'h0);
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_no_wb", dev_mem[3], 16'h5A03);
        access(13'h0023, 1'b1, 1'b0, 16'h0, 1'b0);
        access(13'h0003, 1'b1, 1'b0, 16'h0, 1'b0);
        peek_load(13'h0003, 16'h5A03);

        repeat (2) @(posedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
